// File: rtl/iq_sample_pacer.sv
// iq_sample_pacer: buffers IQ words in a FIFO and re-emits them as paced
// single-cycle strobes at a programmable clock-divided rate, stopping after
// a programmable sample count.
// Optional build macro: IQ_PACER_ZERO_FILL_EN. When it is defined, an
// empty-FIFO slot still strobes, with zero data.
module iq_sample_pacer #(
  parameter int unsigned IQ_WIDTH        = 16,
  parameter int unsigned NUM_CH          = 1,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned DIV_WIDTH       = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            start,
  input  logic [DIV_WIDTH-1:0]            clk_div,
  input  logic [31:0]                     num_sample,
  input  logic [NUM_CH*2*IQ_WIDTH-1:0]    s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [NUM_CH*2*IQ_WIDTH-1:0]    sample_out,
  output logic                            sample_out_strobe,
  output logic [31:0]                     sample_count,
  output logic [FIFO_DEPTH_LOG2:0]        fifo_level,
  output logic                            busy,
  output logic                            done,
  output logic                            underflow
);

  localparam int unsigned DATA_W = NUM_CH * 2 * IQ_WIDTH;
  localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned PTR_W  = FIFO_DEPTH_LOG2;
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [31:0]      COUNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [DATA_W-1:0]      r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [DIV_WIDTH-1:0]   r_phase;
  logic [DIV_WIDTH-1:0]   r_div;
  logic [31:0]            r_num;
  logic [31:0]            w_count_inc;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_start_run;
  logic                   w_slot;
  logic                   w_emit;
  logic                   w_zero;
  logic                   w_uf_set;

  // Ready is derived from the registered level, so a full FIFO never pushes
  assign s_ready     = (fifo_level != LVL_FULL);
  assign w_push      = s_valid && s_ready;
  assign w_count_inc = (sample_count == COUNT_MAX) ? sample_count : sample_count + 32'd1;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      busy    <= (w_state_next == ST_RUN);
      done    <= (w_state_next == ST_DONE);
    end
  end

  // Next-state and slot decode
  always_comb begin
    w_state_next = r_state;
    w_start_run  = 1'b0;
    w_slot       = 1'b0;
    w_pop        = 1'b0;
    w_emit       = 1'b0;
    w_zero       = 1'b0;
    w_uf_set     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next = ST_RUN;
          w_start_run  = 1'b1;
        end
      end
      ST_RUN: begin
        w_slot = enable && (r_phase == r_div);
        if (w_slot) begin
          if (fifo_level != LVL_W'(0)) begin
            w_pop  = 1'b1;
            w_emit = 1'b1;
          end else begin
            w_uf_set = 1'b1;
`ifdef IQ_PACER_ZERO_FILL_EN
            w_emit = 1'b1;
            w_zero = 1'b1;
`endif
          end
        end
        if (w_emit && (r_num != 32'd0) && (w_count_inc == r_num)) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since pointers gate every read
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_level <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Run latches, pacing phase, counters and registered sample output
  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase           <= '0;
      r_div             <= '0;
      r_num             <= '0;
      sample_count      <= '0;
      underflow         <= 1'b0;
      sample_out        <= '0;
      sample_out_strobe <= 1'b0;
    end else begin
      sample_out_strobe <= w_emit;
      if (w_emit) begin
        sample_out <= w_zero ? DATA_W'(0) : r_mem[r_rd_ptr];
      end
      if (w_start_run) begin
        r_phase      <= '0;
        r_div        <= clk_div;
        r_num        <= num_sample;
        sample_count <= '0;
        underflow    <= 1'b0;
      end else begin
        if ((r_state == ST_RUN) && enable) begin
          r_phase <= w_slot ? DIV_WIDTH'(0) : r_phase + DIV_WIDTH'(1);
        end
        if (w_emit)   sample_count <= w_count_inc;
        if (w_uf_set) underflow    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iq_sample_pacer.sv
// Testbench for iq_sample_pacer (NUM_CH=2 build). Pushed words go to an
// expected queue; a monitor captures every strobe with its cycle number.
module tb_iq_sample_pacer;

  localparam int unsigned W = 64;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         start;
  logic [7:0]   clk_div;
  logic [31:0]  num_sample;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] sample_out;
  logic         sample_out_strobe;
  logic [31:0]  sample_count;
  logic [4:0]   fifo_level;
  logic         busy;
  logic         done;
  logic         underflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] obs_d [$];
  int           obs_c [$];

  iq_sample_pacer #(
    .IQ_WIDTH(16), .NUM_CH(2), .FIFO_DEPTH_LOG2(4), .DIV_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .clk_div(clk_div), .num_sample(num_sample), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .sample_out(sample_out),
    .sample_out_strobe(sample_out_strobe), .sample_count(sample_count),
    .fifo_level(fifo_level), .busy(busy), .done(done), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter: after posedge k and #1, cyc == k
  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (sample_out_strobe === 1'b1) begin
      obs_d.push_back(sample_out);
      obs_c.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_d.delete();
    obs_c.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; enable = 1'b1;
    tick(2);
    reset = 1'b0;
    clear_q();
  endtask

  // Push n words base, base+1, ...; expected queue records accepted ones
  task automatic push_words(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      s_data  = base + W'(i);
      s_valid = 1'b1;
      if (s_ready) exp_q.push_back(s_data);
      tick(1);
    end
    s_valid = 1'b0;
  endtask

  // Pulse start for one cycle; returns the edge that samples it
  task automatic pulse_start(input logic [7:0] div, input logic [31:0] num, output int s_edge);
    clk_div = div; num_sample = num; start = 1'b1;
    s_edge = cyc + 1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; start = 1'b0; s_valid = 1'b0;
    clk_div = '0; num_sample = '0; s_data = '0;
    tick(3);
    checks++; if (sample_out !== 64'd0) begin errors++; $display("FAIL reset_sample_out: got %0h want 0", sample_out); end
    checks++; if (sample_out_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b want 0", sample_out_strobe); end
    checks++; if (sample_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", sample_count); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %0b%0b want 00", busy, done); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %0b want 0", underflow); end
    reset = 1'b0;
    tick(1);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
    clear_q();
  endtask

  task automatic test_paced_run();
    int s;
    clear_q();
    push_words(8, 64'd1);
    checks++; if (fifo_level !== 5'd8) begin errors++; $display("FAIL prefill_level: got %0d want 8", fifo_level); end
    pulse_start(8'd9, 32'd8, s);
    for (int i = 0; i < 200 && done !== 1'b1; i++) tick(1);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL paced_done_timeout: got %0b want 1", done); end
    tick(12);
    checks++; if (obs_d.size() != 8) begin errors++; $display("FAIL paced_strobe_count: got %0d want 8", obs_d.size()); end
    for (int i = 0; i < 8 && i < obs_d.size(); i++) begin
      checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL paced_data[%0d]: got %0h want %0h", i, obs_d[i], exp_q[i]); end
      checks++; if (obs_c[i] != s + 10 * (i + 1)) begin errors++; $display("FAIL paced_time[%0d]: got %0d want %0d", i, obs_c[i], s + 10 * (i + 1)); end
    end
    checks++; if (sample_count !== 32'd8) begin errors++; $display("FAIL paced_count: got %0d want 8", sample_count); end
    checks++; if (underflow !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL paced_uf_busy: got %0b%0b want 00", underflow, busy); end
  endtask

  task automatic test_full_rate();
    int s;
    clear_q();
    clk_div = 8'd0; num_sample = 32'd0;
    for (int i = 0; i < 40; i++) begin
      start   = (i == 0);
      if (i == 0) s = cyc + 1;
      s_data  = {32'(i), 32'(i) + 32'hA5A5_0000};
      s_valid = 1'b1;
      if (s_ready) exp_q.push_back(s_data);
      tick(1);
    end
    start = 1'b0; s_valid = 1'b0;
    tick(5);
    checks++; if (obs_d.size() != 40) begin errors++; $display("FAIL rate_strobe_count: got %0d want 40", obs_d.size()); end
    for (int i = 0; i < 40 && i < obs_d.size(); i++) begin
      checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL rate_data[%0d]: got %0h want %0h", i, obs_d[i], exp_q[i]); end
      checks++; if (obs_c[i] != s + 1 + i) begin errors++; $display("FAIL rate_time[%0d]: got %0d want %0d", i, obs_c[i], s + 1 + i); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rate_busy: got %0b want 1", busy); end
    checks++; if (sample_count !== 32'd40) begin errors++; $display("FAIL rate_count: got %0d want 40", sample_count); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    push_words(20, 64'h100);
    checks++; if (exp_q.size() != 16) begin errors++; $display("FAIL full_accepted: got %0d want 16", exp_q.size()); end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", fifo_level); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %0b want 0", s_ready); end
  endtask

  task automatic test_underflow();
    int s;
    int n_exp;
    do_reset();
    push_words(2, 64'hBEEF_0000);
    pulse_start(8'd3, 32'd4, s);
    tick(30);
`ifdef IQ_PACER_ZERO_FILL_EN
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    n_exp = 4;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL uf_done: got %0b want 1", done); end
`else
    n_exp = 2;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL uf_state: got busy %0b done %0b want 1 0", busy, done); end
`endif
    checks++; if (obs_d.size() != n_exp) begin errors++; $display("FAIL uf_strobes: got %0d want %0d", obs_d.size(), n_exp); end
    for (int i = 0; i < n_exp && i < obs_d.size(); i++) begin
      checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL uf_data[%0d]: got %0h want %0h", i, obs_d[i], exp_q[i]); end
      checks++; if (obs_c[i] != s + 4 * (i + 1)) begin errors++; $display("FAIL uf_time[%0d]: got %0d want %0d", i, obs_c[i], s + 4 * (i + 1)); end
    end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_flag: got %0b want 1", underflow); end
    checks++; if (sample_count !== 32'(n_exp)) begin errors++; $display("FAIL uf_count: got %0d want %0d", sample_count, n_exp); end
  endtask

  task automatic test_enable_stall();
    int s;
    int want [3];
    do_reset();
    push_words(4, 64'h5000);
    pulse_start(8'd4, 32'd3, s);
    tick(7);
    enable = 1'b0;
    tick(5);
    enable = 1'b1;
    tick(15);
    want[0] = s + 5; want[1] = s + 15; want[2] = s + 20;
    checks++; if (obs_d.size() != 3) begin errors++; $display("FAIL stall_strobes: got %0d want 3", obs_d.size()); end
    for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
      checks++; if (obs_c[i] != want[i]) begin errors++; $display("FAIL stall_time[%0d]: got %0d want %0d", i, obs_c[i], want[i]); end
      checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL stall_data[%0d]: got %0h want %0h", i, obs_d[i], exp_q[i]); end
    end
    checks++; if (done !== 1'b1 || fifo_level !== 5'd1) begin errors++; $display("FAIL stall_end: got done %0b level %0d want 1 1", done, fifo_level); end
  endtask

  task automatic test_reset_midrun();
    int s;
    do_reset();
    push_words(6, 64'h7700);
    pulse_start(8'd9, 32'd0, s);
    tick(12);
    reset = 1'b1;
    tick(1);
    checks++; if (fifo_level !== 5'd0 || s_ready !== 1'b1) begin errors++; $display("FAIL midrst_fifo: got level %0d ready %0b want 0 1", fifo_level, s_ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL midrst_flags: got %0b%0b%0b want 000", busy, done, underflow); end
    checks++; if (sample_count !== 32'd0 || sample_out !== 64'd0 || sample_out_strobe !== 1'b0) begin errors++; $display("FAIL midrst_out: got cnt %0d data %0h stb %0b want 0 0 0", sample_count, sample_out, sample_out_strobe); end
    reset = 1'b0;
    clear_q();
    push_words(2, 64'hC0DE_0000);
    pulse_start(8'd1, 32'd2, s);
    tick(8);
    checks++; if (obs_d.size() != 2) begin errors++; $display("FAIL restart_strobes: got %0d want 2", obs_d.size()); end
    for (int i = 0; i < 2 && i < obs_d.size(); i++) begin
      checks++; if (obs_d[i] !== exp_q[i] || obs_c[i] != s + 2 * (i + 1)) begin errors++; $display("FAIL restart[%0d]: got %0h@%0d want %0h@%0d", i, obs_d[i], obs_c[i], exp_q[i], s + 2 * (i + 1)); end
    end
    checks++; if (done !== 1'b1 || sample_count !== 32'd2) begin errors++; $display("FAIL restart_done: got done %0b cnt %0d want 1 2", done, sample_count); end
  endtask

  initial begin
    test_reset();
    test_paced_run();
    test_full_rate();
    test_fifo_full();
    test_underflow();
    test_enable_stall();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iq_sample_pacer.md
# iq_sample_pacer

Synthesizable baseband sample pacer for the OFDM receive path. Accepts multi-channel IQ words over a valid/ready stream into an internal FIFO and re-emits them as single-cycle `sample_out_strobe` pulses at a programmable clock-divided rate (e.g. 200 MHz / 10 = 20 Msps). It stops after a programmable sample count. It sits between the ADC/DMA sample source and the `dot11` receiver's `sample_in`/`sample_in_strobe` inputs, and generalises fixed-ratio, single-channel sample strobing.

## Interface
Parameters:
- `IQ_WIDTH`, 16, bits per I or Q component
- `NUM_CH`, 1, antenna channels per sample word; word = NUM_CH×{I,Q}, ch0 in LSBs, I above Q
- `FIFO_DEPTH_LOG2`, 4, FIFO depth = 2^FIFO_DEPTH_LOG2 words
- `DIV_WIDTH`, 8, width of divider setting

Ports:
- `clock`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  pacing enable; low freezes phase counter
- `start`  in  1  one-cycle pulse; begins a run from IDLE or DONE
- `clk_div`  in  DIV_WIDTH  strobe period = clk_div+1 clocks; latched at start
- `num_sample`  in  32  samples per run; 0 = unlimited; latched at start
- `s_data`  in  NUM_CH*2*IQ_WIDTH  input sample word
- `s_valid`  in  1  input word valid
- `s_ready`  out  1  FIFO not full
- `sample_out`  out  NUM_CH*2*IQ_WIDTH  registered output sample
- `sample_out_strobe`  out  1  one-cycle strobe, sample_out valid
- `sample_count`  out  32  samples emitted this run
- `fifo_level`  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy
- `busy`  out  1  state == RUN
- `done`  out  1  state == DONE
- `underflow`  out  1  sticky: a pacing slot found FIFO empty

## Operation
- FIFO: push on `s_valid && s_ready`; pop only at a pacing slot. `s_ready = (fifo_level != DEPTH)` uses registered level, so there is no push when full even if a pop occurs the same cycle. Push and pop in one cycle when not full or empty leaves level unchanged.
- FIFO accepts pushes in every state, so it can be pre-filled before `start`.
- State machine:
  - IDLE: outputs quiet. `start` moves to RUN; `sample_count` and phase are cleared; `underflow` is cleared; `clk_div` and `num_sample` are latched.
  - RUN: the phase counter counts 0..div_l while `enable` is high. A pacing slot occurs when phase == div_l and `enable` is high; phase then wraps to 0.
    - At a slot with FIFO non-empty: pop, drive `sample_out`, pulse strobe, increment `sample_count`.
    - At a slot with FIFO empty: set `underflow`, no strobe, no count increment.
  - RUN → DONE on the cycle the strobe that makes `sample_count == num_l` is issued, only when num_l ≠ 0.
  - DONE: `done` is high. `start` re-enters RUN with a new latch. Unlimited runs (num_l = 0) never leave RUN except by reset.
- `start` while in RUN is ignored.
- `sample_count` saturates at 2^32−1.
- Reset mid-run returns to IDLE and flushes the FIFO; in-flight data is discarded.

## Timing
- Reset values: `sample_out`=0, `sample_out_strobe`=0, `sample_count`=0, `fifo_level`=0, `busy`=0, `done`=0, `underflow`=0. `s_ready`=1 in the first cycle after reset.
- First strobe comes div_l+1 enabled cycles after the `start` edge. Strobes then repeat every div_l+1 enabled cycles.
- div_l = 0 gives a strobe every cycle; the FIFO must then sustain full rate.
- `sample_out` and `sample_out_strobe` are registered and change together. `sample_out` holds its value between strobes.
- A word pushed in cycle n is poppable from cycle n+1, i.e. fall-through latency is 1.
- `enable` low stalls phase with no strobe and no state change. Deasserting `enable` on a slot cycle suppresses that slot.

## Configuration
- `IQ_PACER_ZERO_FILL_EN` defined: at an empty-FIFO slot the block still pulses `sample_out_strobe` with `sample_out` = 0 and increments `sample_count`. `underflow` is still set. This keeps a constant sample rate for the receiver.
- Not defined: empty slots are skipped as described in Operation.

## Test plan
- `clk_div`=9, `num_sample`=8, FIFO pre-filled with 8 words 1..8, `start` → strobes every 10 clocks, first 10 clocks after `start`, data 1..8 in order, `done`=1 after the 8th strobe, `underflow`=0.
- `clk_div`=0, NUM_CH=2, continuous `s_valid` with incrementing data, `num_sample`=0 → strobe every cycle, no gaps after fill, `busy` stays 1, no data drop or duplicate.
- FIFO filled to 16 with no `start` → `s_ready`=0 and `fifo_level`=16; further `s_valid` is not accepted.
- `clk_div`=3, only 2 words supplied, `num_sample`=4 → 2 strobes, then `underflow`=1 with `sample_count`=2. With `IQ_PACER_ZERO_FILL_EN`: 4 strobes, last two zero, `done`=1.
- `enable` low for 5 cycles mid-period at `clk_div`=4 → next strobe delayed by exactly 5 cycles.
- `reset` asserted mid-run with 6 words queued → next cycle IDLE, `fifo_level`=0, all outputs at reset values; a fresh `start` runs cleanly.
